sal_axi_r_buf: RTL and testbench

- Sits on the read path around the DDR controller.
- Upstream of the controller's AXI AR port: forwards AR requests only when enough read-data buffer space is reserved for the whole burst.
- Downstream of the controller's AXI R port: absorbs R beats into a FIFO. The controller cannot stall DFI read data, so the master may back-pressure R without data loss.

---
 rtl/sal_axi_r_buf.sv | 127 ++++++++++++
 tb/tb_sal_axi_r_buf.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sal_axi_r_buf.sv
// AXI read-path buffer: admits AR bursts only against reserved R FIFO space, absorbs unstallable R beats.
// Latency: AR is combinational pass-through; an R beat written in cycle N is visible on s_r* in cycle N+1.
// Backpressure: AR is held until credits >= s_arlen+1; the master may stall R freely. SAL_R_BUF_STALL_CNT_EN adds the stall counter.
module sal_axi_r_buf #(
    parameter int ID_W   = 4,
    parameter int DATA_W = 128,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [31:0]       s_araddr,
    input  logic [7:0]        s_arlen,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ID_W-1:0]   m_arid,
    output logic [31:0]       m_araddr,
    output logic [7:0]        m_arlen,
    input  logic              c_rvalid,
    input  logic [ID_W-1:0]   c_rid,
    input  logic [DATA_W-1:0] c_rdata,
    input  logic [1:0]        c_rresp,
    input  logic              c_rlast,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [ID_W-1:0]   s_rid,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic [CNT_W-1:0]  credits_o,
    output logic [CNT_W-1:0]  occ_o,
    output logic              err_ovf_o,
    output logic              err_oversize_o,
    output logic [31:0]       stall_cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = ID_W + DATA_W + 3;
    // Wide enough for both the credit count plus one bit and s_arlen+1 (up to 256).
    localparam int CMP_W = (CNT_W + 1 > 9) ? CNT_W + 1 : 9;

    logic [CNT_W-1:0] r_credits;
    logic [CNT_W-1:0] r_occ;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic             r_err_ovf;
    logic             r_err_oversize;
    logic [ENT_W-1:0] r_mem [DEPTH];

    logic [CMP_W-1:0] w_need;
    logic [CMP_W-1:0] w_have;
    logic             w_ok;
    logic             w_oversize;
    logic             w_ar_hs;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_rd_ent;

    assign w_need     = CMP_W'(s_arlen) + CMP_W'(1);
    assign w_have     = CMP_W'(r_credits);
    assign w_ok       = (w_have >= w_need);
    assign w_oversize = (w_need > CMP_W'(DEPTH));

    assign m_arvalid = s_arvalid & w_ok;
    assign s_arready = m_arready & w_ok;
    assign m_arid    = s_arid;
    assign m_araddr  = s_araddr;
    assign m_arlen   = s_arlen;
    assign w_ar_hs   = s_arvalid & s_arready;

    assign s_rvalid = (r_occ != '0);
    assign w_pop    = s_rvalid & s_rready;
    assign w_full   = (r_occ == CNT_W'(DEPTH));
    // At full, a same-cycle pop frees the slot being written, so the beat is kept.
    assign w_push   = c_rvalid & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits      <= CNT_W'(DEPTH);
            r_occ          <= '0;
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_err_ovf      <= 1'b0;
            r_err_oversize <= 1'b0;
        end else begin
            // A handshake implies w_need <= r_credits, so the truncation is lossless.
            r_credits <= r_credits - (w_ar_hs ? CNT_W'(w_need) : '0) + CNT_W'(w_pop);
            r_occ     <= r_occ + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            if (c_rvalid & ~w_push)      r_err_ovf      <= 1'b1;
            if (s_arvalid & w_oversize)  r_err_oversize <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {c_rid, c_rdata, c_rresp, c_rlast};
    end

    assign w_rd_ent = r_mem[r_rptr];
    assign {s_rid, s_rdata, s_rresp, s_rlast} = w_rd_ent;

    assign credits_o      = r_credits;
    assign occ_o          = r_occ;
    assign err_ovf_o      = r_err_ovf;
    assign err_oversize_o = r_err_oversize;

`ifdef SAL_R_BUF_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (s_arvalid & ~w_ok & (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sal_axi_r_buf.sv
// Scoreboard bench for sal_axi_r_buf: expected R beats are queued at injection and checked by an independent monitor.
module tb_sal_axi_r_buf;
    localparam int ID_W   = 4;
    localparam int DATA_W = 128;
    localparam int DEPTH  = 64;
    localparam int CNT_W  = 7;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } beat_t;

    logic              clk, rst_n;
    logic              s_arvalid, s_arready, m_arvalid, m_arready;
    logic [ID_W-1:0]   s_arid, m_arid;
    logic [31:0]       s_araddr, m_araddr;
    logic [7:0]        s_arlen, m_arlen;
    logic              c_rvalid, c_rlast;
    logic [ID_W-1:0]   c_rid;
    logic [DATA_W-1:0] c_rdata;
    logic [1:0]        c_rresp;
    logic              s_rvalid, s_rready, s_rlast;
    logic [ID_W-1:0]   s_rid;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;
    logic [CNT_W-1:0]  credits_o, occ_o;
    logic              err_ovf_o, err_oversize_o;
    logic [31:0]       stall_cnt_o;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t sb[$];

    sal_axi_r_buf #(.ID_W(ID_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
        .s_araddr(s_araddr), .s_arlen(s_arlen),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
        .m_araddr(m_araddr), .m_arlen(m_arlen),
        .c_rvalid(c_rvalid), .c_rid(c_rid), .c_rdata(c_rdata),
        .c_rresp(c_rresp), .c_rlast(c_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .credits_o(credits_o), .occ_o(occ_o),
        .err_ovf_o(err_ovf_o), .err_oversize_o(err_oversize_o),
        .stall_cnt_o(stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [159:0] act, logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic beat_t mk(int k);
        logic [31:0] kv;
        beat_t b;
        kv     = k;
        b.id   = kv[3:0];
        b.data = {kv, ~kv, kv ^ 32'h5A5A_5A5A, 32'hC0DE_0000 | kv};
        b.resp = kv[1:0];
        b.last = (kv[1:0] == 2'd0);
        return b;
    endfunction

    // Monitor: every accepted R beat must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && s_rvalid && s_rready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL r_beat_unexpected: got %0h expected none", {s_rid, s_rdata, s_rresp, s_rlast});
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("r_beat", 160'({s_rid, s_rdata, s_rresp, s_rlast}), 160'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(int k);
        beat_t b;
        b        = mk(k);
        c_rvalid = 1'b1;
        c_rid    = b.id;
        c_rdata  = b.data;
        c_rresp  = b.resp;
        c_rlast  = b.last;
    endtask

    task automatic push_beats(int first, int n);
        for (int i = 0; i < n; i++) begin
            drive_beat(first + i);
            sb.push_back(mk(first + i));
            tick();
        end
        c_rvalid = 1'b0;
    endtask

    task automatic ar(int len);
        s_arvalid = 1'b1;
        s_arlen   = 8'(len);
        s_arid    = 4'd1;
        s_araddr  = 32'h0000_1000;
    endtask

    task automatic drain(int budget);
        bit done;
        done     = 1'b0;
        s_rready = 1'b1;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !s_rvalid) done = 1'b1;
        end
        chk("drain_done", 160'(done), 160'(1));
        tick();
        s_rready = 1'b0;
    endtask

    task automatic do_reset();
        s_arvalid = 1'b0;
        c_rvalid  = 1'b0;
        s_rready  = 1'b0;
        rst_n     = 1'b0;
        sb.delete();
    endtask

    task automatic chk_reset_state(string tag);
        chk({tag, "_credits"},  160'(credits_o),      160'(DEPTH));
        chk({tag, "_occ"},      160'(occ_o),          160'(0));
        chk({tag, "_rvalid"},   160'(s_rvalid),       160'(0));
        chk({tag, "_ovf"},      160'(err_ovf_o),      160'(0));
        chk({tag, "_oversize"}, 160'(err_oversize_o), 160'(0));
        chk({tag, "_stall"},    160'(stall_cnt_o),    160'(0));
    endtask

    initial begin
        rst_n = 1'b0; s_arvalid = 1'b0; s_arid = '0; s_araddr = '0; s_arlen = '0;
        m_arready = 1'b0; c_rvalid = 1'b0; c_rid = '0; c_rdata = '0; c_rresp = '0;
        c_rlast = 1'b0; s_rready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_state("rst");
        chk("rst_m_arvalid", 160'(m_arvalid), 160'(0));

        // Single 4-beat burst end to end
        tick();
        m_arready = 1'b1;
        ar(3);
        @(negedge clk);
        chk("t1_m_arvalid", 160'(m_arvalid), 160'(1));
        chk("t1_s_arready", 160'(s_arready), 160'(1));
        chk("t1_m_araddr",  160'(m_araddr),  160'(32'h0000_1000));
        tick();
        s_arvalid = 1'b0;
        @(negedge clk);
        chk("t1_credits", 160'(credits_o), 160'(60));
        tick();
        s_rready = 1'b1;
        drive_beat(1);
        sb.push_back(mk(1));
        @(negedge clk);
        chk("t1_no_bypass", 160'(s_rvalid), 160'(0));
        tick();
        push_beats(2, 3);
        drain(20);
        @(negedge clk);
        chk("t1_credits_back", 160'(credits_o), 160'(DEPTH));
        tick();

        // Fill to 64 with four len=15 bursts, master stalled
        s_rready = 1'b0;
        ar(15);
        repeat (4) tick();
        s_arvalid = 1'b0;
        @(negedge clk);
        chk("t2_credits_zero", 160'(credits_o), 160'(0));
        tick();
        push_beats(100, 64);
        @(negedge clk);
        chk("t2_occ_full", 160'(occ_o), 160'(64));
        chk("t2_no_ovf",   160'(err_ovf_o), 160'(0));
        tick();
        ar(0);
        @(negedge clk);
        chk("t2_stall_a", 160'(m_arvalid), 160'(0));
        chk("t2_stall_s_arready", 160'(s_arready), 160'(0));
        tick();
        s_rready = 1'b1;
        @(negedge clk);
        chk("t2_stall_pop_cycle", 160'(m_arvalid), 160'(0));
        tick();
        s_rready = 1'b0;
        @(negedge clk);
        chk("t2_admit_after_pop", 160'(m_arvalid), 160'(1));
        chk("t2_credits_one", 160'(credits_o), 160'(1));
        tick();
        s_arvalid = 1'b0;
        @(negedge clk);
        chk("t2_credits_after", 160'(credits_o), 160'(0));
        chk("t2_occ_63", 160'(occ_o), 160'(63));
        tick();

        // Full FIFO with simultaneous push/pop across pointer wrap
        push_beats(164, 1);
        @(negedge clk);
        chk("t3_occ_full", 160'(occ_o), 160'(64));
        tick();
        s_rready = 1'b1;
        push_beats(165, 63);
        @(negedge clk);
        chk("t3_occ_stays_full", 160'(occ_o), 160'(64));
        chk("t3_no_ovf", 160'(err_ovf_o), 160'(0));
        tick();
        drain(200);
        do_reset();
        tick();
        rst_n = 1'b1;

        // AR handshake with a same-cycle pop: admission uses pre-pop credits
        m_arready = 1'b1;
        ar(55);
        tick();
        s_arvalid = 1'b0;
        @(negedge clk);
        chk("t6_credits_8", 160'(credits_o), 160'(8));
        tick();
        push_beats(300, 1);
        ar(7);
        s_rready = 1'b1;
        @(negedge clk);
        chk("t6_admit_8", 160'(m_arvalid), 160'(1));
        tick();
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        @(negedge clk);
        chk("t6_credits_1", 160'(credits_o), 160'(1));
        chk("t6_occ_0", 160'(occ_o), 160'(0));
        tick();
        push_beats(301, 1);
        ar(1);
        s_rready = 1'b1;
        @(negedge clk);
        chk("t6_prepop_reject", 160'(m_arvalid), 160'(0));
        tick();
        s_rready = 1'b0;
        @(negedge clk);
        chk("t6_credits_2", 160'(credits_o), 160'(2));
        chk("t6_admit_2", 160'(m_arvalid), 160'(1));
        tick();
        s_arvalid = 1'b0;
        @(negedge clk);
        chk("t6_credits_0", 160'(credits_o), 160'(0));
        tick();
        do_reset();
        tick();
        rst_n = 1'b1;

        // Oversize burst never admitted; len=63 at the boundary is
        @(negedge clk);
        chk("t4_stall_start", 160'(stall_cnt_o), 160'(0));
        tick();
        ar(64);
        @(negedge clk);
        chk("t4_m_arvalid_0", 160'(m_arvalid), 160'(0));
        chk("t4_oversize_pre", 160'(err_oversize_o), 160'(0));
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk("t4_m_arvalid", 160'(m_arvalid), 160'(0));
        end
        chk("t4_oversize", 160'(err_oversize_o), 160'(1));
        chk("t4_credits", 160'(credits_o), 160'(DEPTH));
`ifdef SAL_R_BUF_STALL_CNT_EN
        chk("t4_stall_cnt", 160'(stall_cnt_o), 160'(5));
`else
        chk("t4_stall_cnt", 160'(stall_cnt_o), 160'(0));
`endif
        s_arlen = 8'd63;
        tick();
        s_arvalid = 1'b0;
        @(negedge clk);
        chk("t4_len64_admitted", 160'(credits_o), 160'(0));
        chk("t4_oversize_sticky", 160'(err_oversize_o), 160'(1));
        tick();

        // Overflow write at full, then reset mid-burst
        push_beats(400, 64);
        drive_beat(999);
        tick();
        c_rvalid = 1'b0;
        @(negedge clk);
        chk("t5_ovf", 160'(err_ovf_o), 160'(1));
        chk("t5_occ", 160'(occ_o), 160'(64));
        tick();
        s_rready = 1'b1;
        repeat (2) tick();
        s_rready = 1'b0;
        drive_beat(402);
        tick();
        do_reset();
        @(negedge clk);
        chk_reset_state("t5_midrst");
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("end_sb_empty", 160'(sb.size()), 160'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
